// File: rtl/ram_pattern_checker_if.sv
// RAM read-port bundle between the pattern checker and the RAM under test.
// The checker drives address/enable; the RAM returns data LATENCY clocks later.
interface ram_pattern_checker_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] raddr;
   logic                  ren;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output raddr,
      output ren,
      input  rdata
   );

   modport slave (
      input  raddr,
      input  ren,
      output rdata
   );
endinterface

// File: rtl/ram_pattern_checker.sv
// Sweeps a RAM read port, expecting each word to hold its own address,
// and records mismatch statistics plus the first failing address/data.
module ram_pattern_checker #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(10'h100)
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  stop,
   ram_pattern_checker_if.master ram,
   output logic                  busy,
   output logic                  error,
   output logic [15:0]           err_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic [7:0]            pass_count
);

   typedef enum logic [1:0] {
      IDLE,
      WARMUP,
      CHECK,
      DRAIN
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;
   localparam logic [2:0]            DRAIN_LAST = 3'(LATENCY - 1);

   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
   logic [2:0]            dcnt_q, dcnt_d;

   logic [LATENCY-1:0]                 pv_q, pv_d;
   logic [LATENCY-1:0][ADDR_WIDTH-1:0] pa_q, pa_d;

   logic                  error_q, error_d;
   logic [15:0]           errc_q, errc_d;
   logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
   logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
   logic [7:0]            pass_q, pass_d;

   logic                  issue_chk;
   logic                  launch;
   logic                  cmp_v;
   logic [ADDR_WIDTH-1:0] cmp_a;
   logic [DATA_WIDTH-1:0] exp_data;
   logic                  mism;

   assign cmp_v    = pv_q[LATENCY-1];
   assign cmp_a    = pa_q[LATENCY-1];
   assign exp_data = DATA_WIDTH'(cmp_a);
   assign mism     = cmp_v && (ram.rdata != exp_data);
   assign launch   = (state_q == IDLE) && start;

   assign ram.raddr = raddr_q;
   assign ram.ren   = (state_q == WARMUP) || (state_q == CHECK);
   assign busy      = (state_q != IDLE);

   assign error      = error_q;
   assign err_count  = errc_q;
   assign fail_addr  = faddr_q;
   assign fail_data  = fdata_q;
   assign pass_count = pass_q;

   always_comb begin
      state_d   = state_q;
      raddr_d   = raddr_q;
      wcnt_d    = wcnt_q;
      dcnt_d    = dcnt_q;
      issue_chk = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WARMUP;
               raddr_d = START_ADDR;
               wcnt_d  = '0;
            end
         end
         WARMUP: begin
            if (stop) begin
               state_d = DRAIN;
               dcnt_d  = '0;
            end else begin
               raddr_d = raddr_q + ADDR_WIDTH'(1);
               wcnt_d  = wcnt_q + ADDR_WIDTH'(1);
               // last of the 2^ADDR_WIDTH warm-up reads goes out this edge
               if (wcnt_q == ADDR_MAX) state_d = CHECK;
            end
         end
         CHECK: begin
            issue_chk = 1'b1;
            if (stop) begin
               state_d = DRAIN;
               dcnt_d  = '0;
            end else begin
               raddr_d = raddr_q + ADDR_WIDTH'(1);
            end
         end
         DRAIN: begin
            dcnt_d = dcnt_q + 3'd1;
            if (dcnt_q == DRAIN_LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pv_d    = pv_q;
      pa_d    = pa_q;
      pv_d[0] = issue_chk;
      pa_d[0] = raddr_q;
      for (int i = 1; i < LATENCY; i++) begin
         pv_d[i] = pv_q[i-1];
         pa_d[i] = pa_q[i-1];
      end

      error_d = error_q;
      errc_d  = errc_q;
      faddr_d = faddr_q;
      fdata_d = fdata_q;
      pass_d  = pass_q;
      if (launch) begin
         error_d = 1'b0;
         errc_d  = '0;
         faddr_d = '0;
         fdata_d = '0;
         pass_d  = '0;
      end else begin
         if (mism) begin
            if (errc_q != 16'hFFFF) errc_d = errc_q + 16'd1;
            if (!error_q) begin
               error_d = 1'b1;
               faddr_d = cmp_a;
               fdata_d = ram.rdata;
            end
         end
         if (cmp_v && (cmp_a == ADDR_MAX)) pass_d = pass_q + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         raddr_q <= START_ADDR;
         wcnt_q  <= '0;
         dcnt_q  <= '0;
         pv_q    <= '0;
         pa_q    <= '0;
         error_q <= 1'b0;
         errc_q  <= '0;
         faddr_q <= '0;
         fdata_q <= '0;
         pass_q  <= '0;
      end else begin
         state_q <= state_d;
         raddr_q <= raddr_d;
         wcnt_q  <= wcnt_d;
         dcnt_q  <= dcnt_d;
         pv_q    <= pv_d;
         pa_q    <= pa_d;
         error_q <= error_d;
         errc_q  <= errc_d;
         faddr_q <= faddr_d;
         fdata_q <= fdata_d;
         pass_q  <= pass_d;
      end
   end

endmodule

// File: doc/ram_pattern_checker.md
RAM_PATTERN_CHECKER -- requirements
Module: ram_pattern_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the RAM read data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, width of the RAM read address.
REQ-003 SHALL have parameter LATENCY, default 2, clocks from ren/raddr to valid rdata; legal range 1..4.
REQ-004 SHALL have parameter START_ADDR, default 10'h100, first read address after start.
REQ-005 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-006 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a test run.
REQ-008 SHALL have port stop  input  1  one-cycle request to end the run.
REQ-009 SHALL have port raddr  output  ADDR_WIDTH  RAM read-port address.
REQ-010 SHALL have port ren  output  1  RAM read-port enable.
REQ-011 SHALL have port rdata  input  DATA_WIDTH  RAM read-port data, valid LATENCY clocks after ren.
REQ-012 SHALL have port busy  output  1  high in any state except IDLE.
REQ-013 SHALL have port error  output  1  sticky, high after the first mismatch.
REQ-014 SHALL have port err_count  output  16  number of mismatches, saturating.
REQ-015 SHALL have port fail_addr  output  ADDR_WIDTH  address of the first mismatch.
REQ-016 SHALL have port fail_data  output  DATA_WIDTH  rdata captured at the first mismatch.
REQ-017 SHALL have port pass_count  output  8  completed checked passes, modulo 256.

Function
REQ-018 SHALL implement FSM states IDLE, WARMUP, CHECK and DRAIN; the reset state SHALL be IDLE.
REQ-019 IDLE -> WARMUP on start; the same edge SHALL load raddr=START_ADDR, clear error, err_count, fail_addr, fail_data and pass_count, and assert ren.
REQ-020 In WARMUP and CHECK, ren SHALL be 1 and raddr SHALL increment by 1 each clock, wrapping from 2^ADDR_WIDTH-1 to 0.
REQ-021 WARMUP -> CHECK after exactly 2^ADDR_WIDTH reads have been issued; reads issued in WARMUP SHALL NOT be compared.
REQ-022 Every read issued in CHECK SHALL be compared LATENCY clocks later via an address/valid delay line of depth LATENCY.
REQ-023 Expected data for address a SHALL be a[DATA_WIDTH-1:0], zero-extended when DATA_WIDTH > ADDR_WIDTH.
REQ-024 On a mismatch, err_count SHALL increment by 1 and hold at 16'hFFFF once saturated.
REQ-025 On the first mismatch only, fail_addr and fail_data SHALL be captured, and error SHALL go 1 on the following clock edge.
REQ-026 pass_count SHALL increment whenever a compared address equals 2^ADDR_WIDTH-1.
REQ-027 WARMUP or CHECK -> DRAIN on stop; ren SHALL be 0 from that edge on, and raddr SHALL hold its value.
REQ-028 DRAIN SHALL last LATENCY clocks; in-flight CHECK reads SHALL still be compared; DRAIN -> IDLE afterwards.
REQ-029 start SHALL be ignored outside IDLE; if start and stop are both high in IDLE, start SHALL win; stop SHALL be ignored in IDLE and DRAIN.
REQ-030 In IDLE, ren SHALL be 0, and all result outputs SHALL hold their values until the next start.

Reset
REQ-031 On resetn low, the block SHALL be in IDLE with raddr=START_ADDR, ren=0, busy=0, error=0, err_count=0, fail_addr=0, fail_data=0, pass_count=0, and the delay line cleared.
REQ-032 Reset asserted mid-run SHALL abort the run immediately; no comparison SHALL complete after resetn falls.
REQ-033 After resetn rises, the block SHALL stay in IDLE until a start pulse.

Verification
REQ-034 Defaults; behavioral RAM model always returns the address low byte; start, run 3*1024+10 clocks -> error=0, err_count=0, pass_count=2, ren=1, busy=1.
REQ-035 Same setup, but the model returns 8'h5A at address 10'h123 during the second pass -> error=1, err_count=1, fail_addr=10'h123, fail_data=8'h5A.
REQ-036 Model inverts all data, run 70000 checked reads -> err_count saturates at 16'hFFFF and never wraps to 0.
REQ-037 Stop in CHECK -> ren=0 on the next clock; the last LATENCY reads are still compared; busy falls after exactly LATENCY clocks; a start during DRAIN is ignored.
REQ-038 resetn pulsed low mid-CHECK while errors are present -> all outputs return to their reset values asynchronously; a new start begins WARMUP at raddr=10'h100.
REQ-039 LATENCY=1 and LATENCY=4 builds each pass REQ-034 and REQ-035.
